// File: rtl/fifo_credit_sender.sv
// Credit-based write qualifier for a FIFO that overwrites on full.
// Holds one credit per free FIFO entry and registers each accepted beat toward the FIFO.
module fifo_credit_sender #(
   parameter int ENT_NUM   = 4,
   parameter int CRD_WIDTH = $clog2(ENT_NUM + 1),
   parameter int DATA_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 src_vld,
   input  logic [DATA_SIZE-1:0] src_data,
   output logic                 src_rdy,
   output logic                 in_vld,
   output logic [DATA_SIZE-1:0] in_data,
   input  logic                 credit_rtn,
   output logic [CRD_WIDTH-1:0] crd_cnt,
   output logic                 idle,
   output logic                 err_ovf
);

   localparam logic [CRD_WIDTH-1:0] LP_CRD_FULL = CRD_WIDTH'(ENT_NUM);

   logic [CRD_WIDTH-1:0] r_crd_cnt;
   logic                 r_in_vld;
   logic [DATA_SIZE-1:0] r_in_data;
   logic                 r_err_ovf;
   logic                 w_src_rdy;
   logic                 w_accept;

   // Ready comes from the registered count only, so a returning credit is usable next cycle.
   assign w_src_rdy = (r_crd_cnt != '0);
   assign w_accept  = src_vld & w_src_rdy;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crd_cnt <= LP_CRD_FULL;
         r_in_vld  <= 1'b0;
         r_in_data <= '0;
         r_err_ovf <= 1'b0;
      end else begin
         r_in_vld <= w_accept;
         if (w_accept) begin
            r_in_data <= src_data;
         end
         if (w_accept && !credit_rtn) begin
            r_crd_cnt <= r_crd_cnt - 1'b1;
         end else if (credit_rtn && !w_accept) begin
            // A return with every credit already home means the FIFO and sender disagree.
            if (r_crd_cnt == LP_CRD_FULL) begin
               r_err_ovf <= 1'b1;
            end else begin
               r_crd_cnt <= r_crd_cnt + 1'b1;
            end
         end
      end
   end

   assign src_rdy = w_src_rdy;
   assign in_vld  = r_in_vld;
   assign in_data = r_in_data;
   assign crd_cnt = r_crd_cnt;
   assign err_ovf = r_err_ovf;
   assign idle    = (r_crd_cnt == LP_CRD_FULL) && !r_in_vld;

endmodule
